// File: rtl/mul_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit holding architectural HI/LO, with MTHI/MTLO writes.
// Latency: accept edge + WIDTH iteration edges + one fix-up edge (MULT/MULTU: accept + fix-up with MDU_FAST_MUL_EN).
// Backpressure: none; start is ignored while busy, and MT writes are ignored while busy or when start is high.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic            is_div;
    logic            neg_main;
    logic            neg_rem;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opb;

    // Operand magnitudes and sign flags; only the signed ops (op[0]==0) look at sign bits.
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & operandA[WIDTH-1];
    assign b_neg     = signed_op & operandB[WIDTH-1];
    assign a_mag     = a_neg ? -operandA : operandA;
    assign b_mag     = b_neg ? -operandB : operandB;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opb};
    // A zero divisor keeps subtracting nothing, so the remainder ends up as |dividend| and the quotient all ones.
    assign div_diff  = div_shift[WIDTH-1:0] - opb;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_main ? -prod : prod;
    assign quo_fix  = neg_main ? -acc_lo : acc_lo;
    assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div   <= op[1];
                        // The quotient of a divide by zero stays all ones whatever the dividend sign.
                        neg_main <= op[1] ? ((a_neg ^ b_neg) & (operandB != '0)) : (a_neg ^ b_neg);
                        neg_rem  <= a_neg;
                        count    <= CW'(WIDTH);
                        busy     <= 1'b1;
                        if (op[1]) begin
                            acc_hi <= '0;
                            acc_lo <= a_mag;
                            opb    <= b_mag;
                            state  <= RUN;
                        end else begin
`ifdef MDU_FAST_MUL_EN
                            {acc_hi, acc_lo} <= fast_prod;
                            opb              <= '0;
                            state            <= FIX;
`else
                            acc_hi <= '0;
                            acc_lo <= b_mag;
                            opb    <= a_mag;
                            state  <= RUN;
`endif
                        end
                    end else begin
                        if (hiWrite) hi <= writeData;
                        if (loWrite) lo <= writeData;
                    end
                end
                RUN: begin
                    count <= count - CW'(1);
                    if (is_div) begin
                        if (div_ge) begin
                            acc_hi <= div_diff;
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    if (count == CW'(1)) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: results, latency, busy/done timing, MT writes, reset abort.
module tb_mul_div_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        hiWrite;
    logic        loWrite;
    logic [31:0] writeData;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    localparam int DIV_LAT = 33;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    mul_div_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operandA(operandA), .operandB(operandB),
        .hiWrite(hiWrite), .loWrite(loWrite), .writeData(writeData),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    // Presents one op for a single accept edge, then scrambles operands to show they are not reused.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1; op = o; operandA = a; operandB = b;
        @(posedge clock); #1;
        start = 1'b0; operandA = $urandom; operandB = $urandom;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < 200) begin
            @(posedge clock); #1;
            edges++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = 2'b00; operandA = '0; operandB = '0;
        hiWrite = 1'b0; loWrite = 1'b0; writeData = '0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic test_multu_max;
        int n;
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multu_busy_after_accept: got %b expected 1", busy); end
        wait_done(n);
        checks++; if (n != MUL_LAT) begin errors++; $display("FAIL multu_latency: got %0d expected %0d", n, MUL_LAT); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_with_done: got %b expected 0", busy); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
        @(posedge clock); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_one_cycle: got %b expected 0", done); end
    endtask

    task automatic test_signed;
        int n;
        issue(2'b00, 32'hFFFF_FFFD, 32'd5);
        wait_done(n);
        checks++; if (n != MUL_LAT) begin errors++; $display("FAIL mult_latency: got %0d expected %0d", n, MUL_LAT); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg_hi: got %h expected ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_neg_lo: got %h expected fffffff1", lo); end
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        checks++; if (n != DIV_LAT) begin errors++; $display("FAIL div_latency: got %0d expected %0d", n, DIV_LAT); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2_lo: got %h expected fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_m7_2_hi: got %h expected ffffffff", hi); end
        issue(2'b10, 32'd7, 32'hFFFF_FFFE);
        wait_done(n);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_m2_lo: got %h expected fffffffd", lo); end
        checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL div_7_m2_hi: got %h expected 00000001", hi); end
        issue(2'b11, 32'd100, 32'd7);
        wait_done(n);
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_100_7_lo: got %h expected 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_100_7_hi: got %h expected 00000002", hi); end
    endtask

    task automatic test_div_boundary;
        int n;
        issue(2'b11, 32'd100, 32'd0);
        wait_done(n);
        checks++; if (n != DIV_LAT) begin errors++; $display("FAIL divu_zero_latency: got %0d expected %0d", n, DIV_LAT); end
        checks++; if (hi !== 32'd100) begin errors++; $display("FAIL divu_zero_hi: got %h expected 00000064", hi); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero_lo: got %h expected ffffffff", lo); end
        issue(2'b10, 32'hFFFF_FFF9, 32'd0);
        wait_done(n);
        checks++; if (hi !== 32'hFFFF_FFF9) begin errors++; $display("FAIL div_zero_neg_hi: got %h expected fffffff9", hi); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_zero_neg_lo: got %h expected ffffffff", lo); end
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h expected 00000000", hi); end
    endtask

    task automatic test_busy_ignored;
        int n;
        int pulses;
        issue(2'b11, 32'd1000, 32'd10);
        repeat (5) @(posedge clock);
        @(negedge clock);
        start = 1'b1; op = 2'b01; operandA = 32'd5; operandB = 32'd5;
        hiWrite = 1'b1; writeData = 32'h1234_5678;
        @(negedge clock);
        start = 1'b0; hiWrite = 1'b0;
        wait_done(n);
        checks++; if (n >= 200) begin errors++; $display("FAIL busy_ign_timeout: got %0d edges expected done", n); end
        checks++; if (lo !== 32'd100) begin errors++; $display("FAIL busy_ign_lo: got %h expected 00000064", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL busy_ign_hi: got %h expected 00000000", hi); end
        pulses = 0;
        repeat (50) begin
            @(posedge clock); #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL busy_ign_extra_activity: got %0d cycles expected 0", pulses); end
    endtask

    task automatic test_mt_write;
        int n;
        @(negedge clock); hiWrite = 1'b1; writeData = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi: got %h expected deadbeef", hi); end
        @(negedge clock); hiWrite = 1'b0; loWrite = 1'b1; writeData = 32'hCAFE_F00D;
        @(posedge clock); #1;
        checks++; if (lo !== 32'hCAFE_F00D) begin errors++; $display("FAIL mtlo: got %h expected cafef00d", lo); end
        checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mtlo_hi_kept: got %h expected deadbeef", hi); end
        @(negedge clock); hiWrite = 1'b1; loWrite = 1'b1; writeData = 32'h0BAD_F00D;
        @(posedge clock); #1;
        checks++; if (hi !== 32'h0BAD_F00D || lo !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL mt_both: got hi=%h lo=%h expected 0badf00d", hi, lo);
        end
        @(negedge clock);
        loWrite = 1'b0; hiWrite = 1'b1; writeData = 32'h1111_1111;
        start = 1'b1; op = 2'b01; operandA = 32'd2; operandB = 32'd3;
        @(posedge clock); #1;
        start = 1'b0; hiWrite = 1'b0;
        checks++; if (hi !== 32'h0BAD_F00D) begin errors++; $display("FAIL mt_start_wins_hi: got %h expected 0badf00d", hi); end
        wait_done(n);
        checks++; if (n != MUL_LAT) begin errors++; $display("FAIL mt_start_latency: got %0d expected %0d", n, MUL_LAT); end
        checks++; if (hi !== 32'd0 || lo !== 32'd6) begin
            errors++; $display("FAIL mt_start_result: got hi=%h lo=%h expected 0/6", hi, lo);
        end
    endtask

    task automatic test_reset_mid_run;
        int pulses;
        issue(2'b11, 32'd50, 32'd3);
        repeat (10) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL midrst_hilo: got hi=%h lo=%h expected 0/0", hi, lo);
        end
        @(negedge clock); reset = 1'b0;
        pulses = 0;
        repeat (50) begin
            @(posedge clock); #1;
            if (done === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_late_done: got %0d pulses expected 0", pulses); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL midrst_lo_after: got %h expected 00000000", lo); end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_signed();
        test_div_boundary();
        test_busy_ignored();
        test_mt_write();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
